// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding APB requester. Takes write/read commands on a
//            valid/ready port, runs the APB SETUP/ACCESS sequence, and returns
//            read data and error status on a valid/ready response port.
//            Optional macro APB_MASTER_TIMEOUT_EN bounds the ACCESS phase to
//            TIMEOUT_CYCLES cycles and then completes with an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter must hold values up to TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_timeout_q;
`endif

  // Transfer sequencer: all bus and response outputs are registered here.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        S_ACCESS: begin
          // A ready slave always wins over an expiring timeout.
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_err_q   <= pslverr;
            rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Command acceptance depends on state only, so it never waits on cmd_valid.
  assign cmd_ready = (state_q == S_IDLE);

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Self-checking bench for apb_master_bridge with a behavioural APB
//            slave (16 words at 0x00-0x3C, error above), a reference memory
//            model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_master_bridge dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic [31:0] pen;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb_q[$];
  int          pen_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] smem [16];
  int          wait_cfg = 1;
  bit          stuck = 1'b0;
  int          acc_cnt = 0;
  int          rr_mode = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 16-word memory below 0x40, error at or above it.
  function automatic exp_t model_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    e = '0;
    idx = int'(addr >> 2);
    if (addr >= 32'h40) e.err = 1'b1;
    else if (wr) ref_mem[idx] = data;
    else e.rdata = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    return e;
  endfunction

  // Slave response, driven away from the active edge; noise outside ACCESS.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (!stuck && acc_cnt >= wait_cfg) begin
        pready  = 1'b1;
        pslverr = (paddr >= 32'h40);
        prdata  = (!pwrite && paddr < 32'h40) ? smem[paddr[5:2]] : $urandom;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end
  end

  // Slave storage commits when the transfer completes.
  initial for (int i = 0; i < 16; i++) smem[i] = '0;
  always @(posedge pclk) begin
    if (!preset && psel && penable && pready && pwrite && paddr < 32'h40)
      smem[paddr[5:2]] <= pwdata;
  end

  // Response consumer.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      case (rr_mode)
        0: rsp_ready = 1'($urandom_range(0, 1));
        1: rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Bus protocol monitor and response scoreboard, sampled on the falling edge.
  int           pen_run = 0;
  bit           prev_setup = 1'b0;
  logic [64:0]  bus_hold = '0;
  bit           hold_v = 1'b0;
  logic [33:0]  rsp_hold = '0;
  always @(negedge pclk) begin
    exp_t e;
    if (preset) begin
      pen_run = 0;
      prev_setup = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (psel && !penable) begin
        check("setup_one_cycle", 128'(prev_setup), 128'(0));
        bus_hold = {pwrite, paddr, pwdata};
      end
      if (psel && penable) begin
        if (pen_run == 0) check("setup_before_access", 128'(prev_setup), 128'(1));
        else check("access_stable", 128'({pwrite, paddr, pwdata}), 128'(bus_hold));
        pen_run++;
      end
      if (!psel && penable) check("penable_without_psel", 128'(penable), 128'(0));
      if (!penable && pen_run > 0) begin
        pen_q.push_back(pen_run);
        pen_run = 0;
      end
      prev_setup = psel && !penable;

      if (hold_v)
        check("rsp_hold", 128'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 128'({1'b1, rsp_hold}));
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got response with nothing expected at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("rsp_fields", 128'({rsp_rdata, rsp_err, rsp_timeout}), 128'({e.rdata, e.err, e.to}));
          if (pen_q.size() == 0) check("penable_cycles", 128'(0), 128'(e.pen));
          else check("penable_cycles", 128'(pen_q.pop_front()), 128'(e.pen));
        end
        hold_v = 1'b0;
      end else if (rsp_valid) begin
        hold_v = 1'b1;
        rsp_hold = {rsp_rdata, rsp_err, rsp_timeout};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Issue one command; returns after acceptance (or after response if chk_lat).
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int w, input bit chk_lat, input bit to_exp);
    exp_t e;
    int   n;
    e = model_cmd(wr, addr, data);
    e.pen = 32'(w + 1);
    if (to_exp) begin
      e.rdata = '0;
      e.err = 1'b1;
      e.to = 1'b1;
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    n = 0;
    forever begin
      @(negedge pclk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 200 cycles expected 1");
        cmd_valid = 1'b0;
        return;
      end
    end
    sb_q.push_back(e);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    wait_cfg  = w;
    if (chk_lat) begin
      n = 0;
      forever begin
        @(negedge pclk);
        n++;
        if (rsp_valid || n > 100) break;
      end
      check("latency", 128'(n), 128'(w + 3));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0) begin
      @(negedge pclk);
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d responses outstanding expected 0", sb_q.size());
        sb_q.delete();
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge pclk);
    #2;
    preset = 1'b1;
    #1;
    check("reset_async_bus", 128'({psel, penable, rsp_valid, cmd_ready}), 128'(4'b0001));
    sb_q.delete();
    repeat (2) @(negedge pclk);
    pen_q.delete();
    stuck = 1'b0;
    @(posedge pclk);
    #1;
    preset = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] d;
    repeat (3) @(negedge pclk);
    check("reset_outputs", 128'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, rsp_rdata}), 128'(0));
    check("reset_cmd_ready", 128'(cmd_ready), 128'(1));
    @(posedge pclk);
    #1;
    preset = 1'b0;

    // Write then read back.
    do_cmd(1'b1, 32'h04, 32'hDEADBEEF, 1, 1'b1, 1'b0);
    drain();
    do_cmd(1'b0, 32'h04, 32'h0, 1, 1'b1, 1'b0);
    drain();

    // Out-of-range read.
    do_cmd(1'b0, 32'h40, 32'h0, 1, 1'b1, 1'b0);
    drain();

    // Long wait-state read.
    do_cmd(1'b1, 32'h08, 32'h12345678, 0, 1'b1, 1'b0);
    drain();
    do_cmd(1'b0, 32'h08, 32'h0, 5, 1'b1, 1'b0);
    drain();

    // Response back-pressure with the next command already waiting.
    rr_mode = 2;
    d = $urandom;
    do_cmd(1'b1, 32'h10, d, 1, 1'b0, 1'b0);
    fork
      do_cmd(1'b0, 32'h10, 32'h0, 2, 1'b0, 1'b0);
      begin
        n = 0;
        while (!rsp_valid && n < 100) begin
          @(negedge pclk);
          n++;
        end
        repeat (4) begin
          @(negedge pclk);
          check("backpressure_ready_valid", 128'({cmd_ready, rsp_valid}), 128'(2'b01));
        end
        rr_mode = 1;
      end
    join
    drain();

    // Reset in the middle of ACCESS.
    stuck = 1'b1;
    do_cmd(1'b0, 32'h0C, 32'h0, 0, 1'b0, 1'b0);
    n = 0;
    while (!(psel && penable) && n < 50) begin
      @(negedge pclk);
      n++;
    end
    repeat (2) @(negedge pclk);
    pulse_reset();
    seen = 0;
    repeat (5) begin
      @(negedge pclk);
      if (rsp_valid) seen++;
    end
    check("abort_no_response", 128'(seen), 128'(0));
    d = $urandom;
    do_cmd(1'b1, 32'h0C, d, 1, 1'b1, 1'b0);
    drain();
    do_cmd(1'b0, 32'h0C, 32'h0, 1, 1'b1, 1'b0);
    drain();

    // Slave that never becomes ready.
    stuck = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    do_cmd(1'b0, 32'h14, 32'h0, 15, 1'b1, 1'b1);
    drain();
    stuck = 1'b0;
`else
    do_cmd(1'b0, 32'h14, 32'h0, 0, 1'b0, 1'b0);
    seen = 0;
    repeat (100) begin
      @(negedge pclk);
      if (rsp_valid) seen++;
    end
    check("stuck_no_response", 128'(seen), 128'(0));
    pulse_reset();
`endif

    // Randomized traffic with random response back-pressure.
    rr_mode = 0;
    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4), $urandom,
             int'($urandom_range(0, 3)), 1'b1, 1'b0);
      drain();
    end
    repeat (3) @(negedge pclk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
